// File: rtl/mem_arb_pkg.sv
// Shared types for the main-memory arbiter: grant FSM states and owner encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } own_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache / D-cache line bursts onto one pipelined memory port.
// MEM_ARB_RR_EN selects round-robin tie-break; default is fixed D-cache priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int BURST  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ic_req,
    input  logic [ADDR_W-1:0]          ic_addr,
    output logic                       ic_rvalid,
    output logic                       ic_done,
    input  logic                       dc_req,
    input  logic                       dc_wr,
    input  logic [ADDR_W-1:0]          dc_addr,
    input  logic [DATA_W-1:0]          dc_wdata,
    output logic                       dc_rvalid,
    output logic                       dc_done,
    output logic [$clog2(BURST)-1:0]   iss_idx,
    output logic [$clog2(BURST)-1:0]   ret_idx,
    output logic [DATA_W-1:0]          rdata,
    output logic                       busy,
    output logic                       mem_en,
    output logic                       mem_wr,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_stall,
    input  logic                       mem_rvalid,
    input  logic [DATA_W-1:0]          mem_rdata
);
    localparam int IDX_W  = $clog2(BURST);
    localparam int BASE_W = ADDR_W - IDX_W;
    localparam int CNT_W  = IDX_W + 1;

    state_e              state_q, state_d;
    own_e                owner_q, owner_d;
    logic                wr_q, wr_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [IDX_W-1:0]    iss_q, iss_d;
    logic [CNT_W-1:0]    ret_q, ret_d;
    own_e                win;
    logic                rd_active, ret_fire, take;

    // Word offset bits of the line addresses are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ic_addr[IDX_W-1:0], dc_addr[IDX_W-1:0]};

`ifdef MEM_ARB_RR_EN
    own_e last_q, last_d;
`endif

    assign rd_active = ((state_q == ISSUE) || (state_q == DRAIN)) && !wr_q;
    assign ret_fire  = rd_active && mem_rvalid;
    assign take      = (state_q == ISSUE) && !mem_stall;

    always_comb begin
        win = dc_req ? OWN_D : OWN_I;
`ifdef MEM_ARB_RR_EN
        if (ic_req && dc_req) win = (last_q == OWN_D) ? OWN_I : OWN_D;
`endif
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        base_d  = base_q;
        iss_d   = iss_q;
        ret_d   = ret_fire ? ret_q + 1'b1 : ret_q;
`ifdef MEM_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                iss_d = '0;
                ret_d = '0;
                if (ic_req || dc_req) begin
                    owner_d = win;
                    wr_d    = (win == OWN_D) && dc_wr;
                    base_d  = (win == OWN_D) ? dc_addr[ADDR_W-1:IDX_W] : ic_addr[ADDR_W-1:IDX_W];
                    state_d = ISSUE;
`ifdef MEM_ARB_RR_EN
                    last_d  = win;
`endif
                end
            end
            ISSUE: begin
                if (take) begin
                    iss_d = iss_q + 1'b1;
                    if (iss_q == IDX_W'(BURST - 1)) begin
                        // Returns trail issue, so a read usually still has data in flight.
                        if (wr_q || (ret_d == CNT_W'(BURST))) state_d = DONE;
                        else                                 state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (ret_d == CNT_W'(BURST)) state_d = DONE;
            end
            DONE: begin
                iss_d   = '0;
                ret_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_D;
            wr_q    <= 1'b0;
            base_q  <= '0;
            iss_q   <= '0;
            ret_q   <= '0;
`ifdef MEM_ARB_RR_EN
            last_q  <= OWN_I;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            base_q  <= base_d;
            iss_q   <= iss_d;
            ret_q   <= ret_d;
`ifdef MEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign mem_en    = (state_q == ISSUE);
    assign mem_wr    = mem_en && wr_q;
    assign mem_addr  = mem_en ? {base_q, iss_q} : '0;
    assign mem_wdata = mem_wr ? dc_wdata : '0;
    assign iss_idx   = iss_q;
    assign ret_idx   = ret_q[IDX_W-1:0];
    assign ic_rvalid = ret_fire && (owner_q == OWN_I);
    assign dc_rvalid = ret_fire && (owner_q == OWN_D);
    assign rdata     = ret_fire ? mem_rdata : '0;
    assign ic_done   = (state_q == DONE) && (owner_q == OWN_I);
    assign dc_done   = (state_q == DONE) && (owner_q == OWN_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected issues/returns/dones queued at stimulus time.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req, dc_req, dc_wr;
    logic [15:0] ic_addr, dc_addr, dc_wdata;
    logic        ic_rvalid, ic_done, dc_rvalid, dc_done;
    logic [1:0]  iss_idx, ret_idx;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        busy, mem_en, mem_wr, mem_stall, mem_rvalid;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .BURST(4)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
        .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_rvalid(dc_rvalid), .dc_done(dc_done),
        .iss_idx(iss_idx), .ret_idx(ret_idx), .rdata(rdata), .busy(busy),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_stall(mem_stall), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct { logic [15:0] addr; logic wr; logic [15:0] wdata; logic [1:0] idx; } iss_t;
    typedef struct { logic own_d; logic [1:0] idx; logic [15:0] data; } ret_t;
    typedef struct { int due; logic [15:0] data; bit legit; } rq_t;

    iss_t exp_iss[$];
    ret_t exp_ret[$];
    bit   exp_done[$];
    rq_t  rq[$];

    int n_chk = 0, n_err = 0;
    int cyc = 0, lat = 2, stall_left = 0, stall_word = 0;
    int ic_left = 0, dc_left = 0, dones = 0, last_done_cyc = 0, req_cyc = 0;
    bit stale_inject = 0, legit = 0;
    logic [15:0] wd_seed = 16'h0;

    assign dc_wdata = wd_seed + {14'd0, iss_idx};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mfn(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic push_burst(input bit own_d, input bit wr, input logic [15:0] addr, input logic [15:0] seed);
        for (int i = 0; i < 4; i++) begin
            iss_t e;
            e.addr  = {addr[15:2], 2'(i)};
            e.wr    = wr;
            e.wdata = wr ? seed + 16'(i) : 16'h0;
            e.idx   = 2'(i);
            exp_iss.push_back(e);
            if (!wr) exp_ret.push_back('{own_d, 2'(i), mfn(e.addr)});
        end
        exp_done.push_back(own_d);
    endtask

    task automatic chk_quiet(input string tag);
        check({tag, "_ctl"}, {busy, mem_en, mem_wr, ic_rvalid, dc_rvalid, ic_done, dc_done}, 7'h0);
        check({tag, "_addr"}, mem_addr, 16'h0);
        check({tag, "_wdata"}, mem_wdata, 16'h0);
        check({tag, "_idx"}, {iss_idx, ret_idx}, 4'h0);
        check({tag, "_rdata"}, rdata, 16'h0);
    endtask

    // One clock: drive memory-side inputs at negedge, then observe and score.
    task automatic step();
        logic any_rv;
        @(negedge clk);
        cyc++;
        mem_stall = 1'b0;
        if (stall_left > 0 && mem_en && iss_idx == 2'(stall_word)) begin
            mem_stall = 1'b1;
            stall_left--;
        end
        legit      = 0;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'($urandom);
        if (rq.size() > 0 && rq[0].due == cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rq[0].data;
            legit      = rq[0].legit;
            void'(rq.pop_front());
        end else if (stale_inject) begin
            mem_rvalid = 1'b1;
        end
        #1;
        any_rv = ic_rvalid | dc_rvalid;
        if (mem_rvalid && legit) check("rv_fwd", any_rv, 1);
        else                     check("rv_none", any_rv, 0);
        if (any_rv && legit) begin
            check("ret_expected", exp_ret.size() != 0, 1);
            if (exp_ret.size() != 0) begin
                ret_t r = exp_ret.pop_front();
                check("ret_own", {ic_rvalid, dc_rvalid}, r.own_d ? 2'b01 : 2'b10);
                check("ret_idx", ret_idx, r.idx);
                check("rdata", rdata, r.data);
            end
        end
        if (mem_en && mem_stall && exp_iss.size() != 0) begin
            check("stall_addr", mem_addr, exp_iss[0].addr);
            check("stall_idx", iss_idx, exp_iss[0].idx);
        end
        if (mem_en && !mem_stall) begin
            check("iss_expected", exp_iss.size() != 0, 1);
            if (exp_iss.size() != 0) begin
                iss_t e = exp_iss.pop_front();
                check("mem_addr", mem_addr, e.addr);
                check("mem_wr", mem_wr, e.wr);
                check("mem_wdata", mem_wdata, e.wdata);
                check("iss_idx", iss_idx, e.idx);
            end
            if (!mem_wr) rq.push_back('{cyc + lat, mfn(mem_addr), 1'b1});
        end
        if (ic_done || dc_done) begin
            check("done_expected", exp_done.size() != 0, 1);
            if (exp_done.size() != 0) begin
                bit d = exp_done.pop_front();
                check("done_own", {ic_done, dc_done}, d ? 2'b01 : 2'b10);
            end
            last_done_cyc = cyc;
            dones++;
            if (ic_done && ic_left > 0) begin ic_left--; if (ic_left == 0) ic_req = 1'b0; end
            if (dc_done && dc_left > 0) begin dc_left--; if (dc_left == 0) dc_req = 1'b0; end
        end
    endtask

    task automatic serve(input int bound);
        int n = 0;
        while ((ic_left > 0 || dc_left > 0) && n < bound) begin
            step();
            n++;
        end
        check("serve_done", (ic_left == 0 && dc_left == 0), 1);
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        int d0;
        rst = 1'b0; ic_req = 0; dc_req = 0; dc_wr = 0;
        ic_addr = 0; dc_addr = 0; mem_stall = 0; mem_rvalid = 0; mem_rdata = 16'hBEEF;
        #1;
        chk_quiet("reset");
        step(); step();
        chk_quiet("reset_hold");
        rst = 1'b1;
        step();

        // D writeback with stale mem_rvalid noise throughout.
        lat = 2; wd_seed = 16'h1230;
        push_burst(1, 1, 16'h0100, wd_seed);
        dc_wr = 1; dc_addr = 16'h0100; dc_left = 1; dc_req = 1; stale_inject = 1;
        req_cyc = cyc;
        serve(40);
        stale_inject = 0;
        check("wb_latency", last_done_cyc - req_cyc, 5);

        // I-only read, latency 2.
        dc_wr = 0;
        push_burst(0, 0, 16'h0043, 16'h0);
        ic_addr = 16'h0043; ic_left = 1; ic_req = 1;
        req_cyc = cyc;
        serve(40);
        check("rd_latency", last_done_cyc - req_cyc, 7);

        // Tie; D holds its request for a second burst.
        lat = 1;
        dc_addr = 16'h0208; ic_addr = 16'h0310;
        push_burst(1, 0, 16'h0208, 16'h0);
`ifdef MEM_ARB_RR_EN
        push_burst(0, 0, 16'h0310, 16'h0);
        push_burst(1, 0, 16'h0208, 16'h0);
`else
        push_burst(1, 0, 16'h0208, 16'h0);
        push_burst(0, 0, 16'h0310, 16'h0);
`endif
        dc_left = 2; ic_left = 1; dc_req = 1; ic_req = 1;
        serve(80);

        // Three stall cycles on word 1.
        lat = 3; stall_word = 1; stall_left = 3;
        push_burst(0, 0, 16'h0404, 16'h0);
        ic_addr = 16'h0404; ic_left = 1; ic_req = 1;
        req_cyc = cyc;
        serve(50);
        check("stall_used", stall_left, 0);
        check("stall_latency", last_done_cyc - req_cyc, 11);

        // Reset while draining a D fill.
        lat = 6;
        push_burst(1, 0, 16'h0500, 16'h0);
        dc_addr = 16'h0500; dc_left = 1; dc_req = 1;
        for (int n = 0; n < 20 && exp_iss.size() != 0; n++) step();
        check("pre_rst_issued", exp_iss.size(), 0);
        step();
        check("pre_rst_busy", busy, 1);
        rst = 1'b0; dc_req = 0; dc_left = 0;
        #1;
        chk_quiet("abort");
        exp_ret.delete();
        exp_done.delete();
        foreach (rq[i]) rq[i].legit = 0;
        step(); step();
        rst = 1'b1;
        for (int n = 0; n < 8; n++) step();
        check("late_ret_gone", rq.size(), 0);

        // I request held across ic_done -> back-to-back bursts.
        lat = 2;
        push_burst(0, 0, 16'h0600, 16'h0);
        push_burst(0, 0, 16'h0600, 16'h0);
        ic_addr = 16'h0600; ic_left = 2; ic_req = 1;
        d0 = dones;
        serve(80);
        check("b2b_dones", dones - d0, 2);

        for (int n = 0; n < 4; n++) step();
        check("iss_left", exp_iss.size(), 0);
        check("ret_left", exp_ret.size(), 0);
        check("done_left", exp_done.size(), 0);
        chk_quiet("end");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
